// File: rtl/mem_pkg.sv
// Shared command/state types and the IO address map for the cpu memory bridge.
package mem_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    DRAIN   = 2'b10
  } bridge_state_t;

  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR  = 9'h140;

  // The unused encoding 2'b11 behaves exactly like no command.
  function automatic mem_cmd_t decode_cmd(input logic [1:0] raw);
    case (raw)
      2'b01:   return MREAD;
      2'b10:   return MWRITE;
      default: return MNONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_wbuf.sv
// Circular FIFO of posted {addr,data} RAM writes. The age-ordered entry view
// (index 0 = oldest) exists only when MEM_BRIDGE_WR_FWD_EN is defined.
module mem_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 9,
  parameter int DW    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [AW-1:0]          push_addr,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [AW-1:0]          head_addr,
  output logic [DW-1:0]          head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
`ifdef MEM_BRIDGE_WR_FWD_EN
  ,
  output logic [DEPTH-1:0]       view_valid,
  output logic [AW-1:0]          view_addr [DEPTH],
  output logic [DW-1:0]          view_data [DEPTH]
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  // Pointers are exactly PW bits wide, so they wrap modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= push_addr;
      data_mem[wr_ptr_q] <= push_data;
    end
  end

  assign head_addr = addr_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;

`ifdef MEM_BRIDGE_WR_FWD_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      view_valid[i] = (CW'(i) < count_q);
      view_addr[i]  = addr_mem[rd_ptr_q + PW'(i)];
      view_data[i]  = data_mem[rd_ptr_q + PW'(i)];
    end
  end
`endif

endmodule

// File: rtl/mem_bridge.sv
// cpu memory/IO bridge: posted write buffer in front of a 512x16 sync RAM plus
// LED/switch registers. Define MEM_BRIDGE_WR_FWD_EN to forward buffered writes to reads.
module mem_bridge
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 9,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    mem_cmd,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] din_ram,
  output logic [DW-1:0] read_mem,
  output logic          mem_ready,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_re,
  input  logic [DW-1:0] ram_rdata,
  input  logic [7:0]    sw_in,
  output logic [7:0]    led_out
);

  // Handshake: a command (MREAD/MWRITE) transfers on a posedge where mem_ready
  // is high; while mem_ready is low the cpu keeps mem_cmd/mem_addr/din_ram stable.

  bridge_state_t   state_q, state_d;
  logic [DW-1:0]   read_mem_q, read_mem_d;
  logic [7:0]      led_q, led_d;
  mem_cmd_t        cmd;
  logic            is_led, is_sw, wr_ram, rd_ram;
  logic            wb_push, wb_pop, wb_full, wb_empty;
  logic [AW-1:0]   wb_head_addr;
  logic [DW-1:0]   wb_head_data;
  logic [$clog2(DEPTH):0] wb_count;

  assign cmd    = decode_cmd(mem_cmd);
  assign is_led = (mem_addr == AW'(LED_ADDR));
  assign is_sw  = (mem_addr == AW'(SW_ADDR));
  assign wr_ram = (cmd == MWRITE) && !is_led;
  assign rd_ram = (cmd == MREAD) && !is_sw;

`ifdef MEM_BRIDGE_WR_FWD_EN
  logic [DEPTH-1:0] wb_view_valid;
  logic [AW-1:0]    wb_view_addr [DEPTH];
  logic [DW-1:0]    wb_view_data [DEPTH];
  logic             fwd_hit;
  logic [DW-1:0]    fwd_data;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_view_valid[i] && (wb_view_addr[i] == mem_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_view_data[i];
      end
    end
  end
`endif

  mem_wbuf #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_wbuf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (wb_push),
    .push_addr (mem_addr),
    .push_data (din_ram),
    .pop       (wb_pop),
    .head_addr (wb_head_addr),
    .head_data (wb_head_data),
    .full      (wb_full),
    .empty     (wb_empty),
    .count     (wb_count)
`ifdef MEM_BRIDGE_WR_FWD_EN
    ,
    .view_valid(wb_view_valid),
    .view_addr (wb_view_addr),
    .view_data (wb_view_data)
`endif
  );

  always_comb begin
    state_d    = state_q;
    read_mem_d = read_mem_q;
    led_d      = led_q;
    mem_ready  = 1'b0;
    ram_re     = 1'b0;
    wb_push    = 1'b0;
    wb_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        mem_ready = !(wr_ram && wb_full);
`ifndef MEM_BRIDGE_WR_FWD_EN
        if (rd_ram && !wb_empty) begin
          mem_ready = 1'b0;
          state_d   = DRAIN;
        end
`endif
        if (mem_ready && (cmd == MWRITE)) begin
          if (is_led) led_d = din_ram[7:0];
          else        wb_push = 1'b1;
        end
        if (mem_ready && (cmd == MREAD)) begin
          if (is_sw) read_mem_d = DW'(sw_in);
`ifdef MEM_BRIDGE_WR_FWD_EN
          else if (fwd_hit) read_mem_d = fwd_data;
`endif
          else begin
            ram_re  = 1'b1;
            state_d = RD_WAIT;
          end
        end
        // An issued read owns the RAM port this cycle.
        wb_pop = !wb_empty && !ram_re;
      end
      RD_WAIT: begin
        read_mem_d = ram_rdata;
        state_d    = IDLE;
      end
      DRAIN: begin
        if (wb_count == '0) state_d = IDLE;
        else                wb_pop  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      read_mem_q <= '0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      read_mem_q <= read_mem_d;
      led_q      <= led_d;
    end
  end

  assign read_mem  = read_mem_q;
  assign led_out   = led_q;
  assign ram_we    = wb_pop;
  assign ram_addr  = ram_re ? mem_addr : wb_head_addr;
  assign ram_wdata = wb_head_data;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed pins plus randomized cpu traffic
// against a queue-based model that tracks program-order memory contents.
module tb_mem_bridge;

  localparam int         DEPTH  = 4;
  localparam logic [8:0] LED_A  = 9'h100;
  localparam logic [8:0] SW_A   = 9'h140;
  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_RD   = 2'b01;
  localparam logic [1:0] C_WR   = 2'b10;
  localparam logic [1:0] C_RSV  = 2'b11;

  bit          clk;
  logic        reset_n;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] din_ram;
  logic [15:0] read_mem;
  logic        mem_ready;
  logic [8:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [15:0] ram_rdata;
  logic [7:0]  sw_in;
  logic [7:0]  led_out;

  int n_tests;
  int n_fail;

  // RAM contents as seen by the RAM port, and as the cpu program order implies.
  logic [15:0] ram_mem  [512];
  logic [15:0] cpu_view [512];

  // Scoreboard: posted writes {addr,data} that must reach the RAM in order.
  logic [24:0] exp_q[$];
  bit          m_wait;
  logic [15:0] m_wait_val;
  bit          m_drain;
  logic [15:0] exp_read;
  logic [7:0]  exp_led;
  bit          is_wr, is_rd, led_hit, sw_hit, e_ready, e_re, e_we, go_drain;

  mem_bridge #(.DEPTH(DEPTH), .AW(9), .DW(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .din_ram   (din_ram),
    .read_mem  (read_mem),
    .mem_ready (mem_ready),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata),
    .sw_in     (sw_in),
    .led_out   (led_out)
  );

  // ---------------- clock / RAM ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= ram_mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got 'h%0h, want 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle model and compare ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      m_wait   = 0;
      m_drain  = 0;
      exp_read = '0;
      exp_led  = '0;
      for (int i = 0; i < 512; i++) cpu_view[i] = ram_mem[i];
      chk("rst_read_mem", read_mem, 0);
      chk("rst_led_out", led_out, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_re", ram_re, 0);
    end else begin
      is_wr    = (mem_cmd == C_WR);
      is_rd    = (mem_cmd == C_RD);
      led_hit  = (mem_addr == LED_A);
      sw_hit   = (mem_addr == SW_A);
      e_ready  = 0;
      e_re     = 0;
      e_we     = 0;
      go_drain = 0;
      if (m_wait) begin
        e_ready = 0;
      end else if (m_drain) begin
        e_we = (exp_q.size() != 0);
      end else begin
        e_ready = !(is_wr && !led_hit && exp_q.size() == DEPTH);
        if (is_rd && !sw_hit) begin
`ifdef MEM_BRIDGE_WR_FWD_EN
          bit f_hit;
          f_hit = 0;
          foreach (exp_q[i]) if (exp_q[i][24:16] == mem_addr) f_hit = 1;
          e_re = !f_hit;
`else
          if (exp_q.size() != 0) begin
            e_ready  = 0;
            go_drain = 1;
          end else begin
            e_re = 1;
          end
`endif
        end
        e_we = (exp_q.size() != 0) && !e_re;
      end

      chk("mem_ready", mem_ready, e_ready);
      chk("read_mem", read_mem, exp_read);
      chk("led_out", led_out, exp_led);
      chk("ram_re", ram_re, e_re);
      chk("ram_we", ram_we, e_we);
      if (e_re) chk("ram_rd_addr", ram_addr, mem_addr);
      if (e_we && ram_we) begin
        chk("ram_wr_addr", ram_addr, exp_q[0][24:16]);
        chk("ram_wr_data", ram_wdata, exp_q[0][15:0]);
      end

      if (m_wait) begin
        exp_read = m_wait_val;
        m_wait   = 0;
      end else if (m_drain) begin
        if (exp_q.size() == 0) m_drain = 0;
      end else if (go_drain) begin
        m_drain = 1;
      end
      if (e_we) void'(exp_q.pop_front());
      if (e_ready && is_wr) begin
        if (led_hit) exp_led = din_ram[7:0];
        else begin
          exp_q.push_back({mem_addr, din_ram});
          cpu_view[mem_addr] = din_ram;
        end
      end
      if (e_ready && is_rd) begin
        if (sw_hit) exp_read = {8'h00, sw_in};
        else if (e_re) begin
          m_wait     = 1;
          m_wait_val = cpu_view[mem_addr];
        end else exp_read = cpu_view[mem_addr];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset(input int cycles);
    mem_cmd = C_NONE;
    reset_n = 0;
    repeat (cycles) @(posedge clk);
    #1;
    chk("reset_read_mem", read_mem, 16'h0000);
    chk("reset_led_out", led_out, 8'h00);
    chk("reset_ram_we", ram_we, 1'b0);
    reset_n = 1;
  endtask

  task automatic idle(input logic [1:0] c, input int n);
    mem_cmd = c;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    mem_cmd = C_NONE;
  endtask

  task automatic do_cmd(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    bit acc;
    int waited;
    acc      = 0;
    waited   = 0;
    mem_cmd  = c;
    mem_addr = a;
    din_ram  = d;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = mem_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    n_tests++;
    if (!acc) begin
      n_fail++;
      $display("FAIL accept_timeout: cmd %0d addr 'h%0h still not accepted, want accept within 50 cycles", c, a);
    end
    mem_cmd = C_NONE;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [8:0]  a;
    logic [15:0] d;
    int          sel;
    n_tests  = 0;
    n_fail   = 0;
    mem_cmd  = C_NONE;
    mem_addr = '0;
    din_ram  = '0;
    sw_in    = '0;
    reset_n  = 0;
    for (int i = 0; i < 512; i++) ram_mem[i] = 16'($urandom);
    ram_mem[9'h0FF] = 16'h1234;
    ram_mem[9'h030] = 16'h5A5A;
    apply_reset(3);

    do_cmd(C_WR, LED_A, 16'h00A5);
    chk("led_write", led_out, 8'hA5);
    sw_in = 8'h3C;
    do_cmd(C_RD, SW_A, 16'h0000);
    chk("sw_read", read_mem, 16'h003C);

    do_cmd(C_RD, 9'h0FF, 16'h0000);
    idle(C_NONE, 2);
    chk("ram_read_0ff", read_mem, 16'h1234);
    idle(C_RSV, 3);
    chk("rsv_cmd_read_mem", read_mem, 16'h1234);
    chk("rsv_cmd_led", led_out, 8'hA5);

    do_cmd(C_WR, 9'h020, 16'hBEEF);
    do_cmd(C_RD, 9'h020, 16'h0000);
    idle(C_NONE, 2);
    chk("raw_beef", read_mem, 16'hBEEF);
    do_cmd(C_WR, 9'h020, 16'h1111);
    do_cmd(C_WR, 9'h020, 16'h2222);
    do_cmd(C_RD, 9'h020, 16'h0000);
    idle(C_NONE, 2);
    chk("raw_youngest", read_mem, 16'h2222);

    for (int i = 0; i < 5; i++) do_cmd(C_WR, 9'h010 + 9'(i), 16'hA000 + 16'(i));
    idle(C_NONE, 4);
    for (int i = 0; i < 5; i++) chk("burst_ram_data", ram_mem[9'h010 + 9'(i)], 16'hA000 + 16'(i));

    do_cmd(C_WR, 9'h030, 16'hDEAD);
    apply_reset(2);
    do_cmd(C_RD, 9'h030, 16'h0000);
    idle(C_NONE, 2);
    chk("lost_posted_write", read_mem, 16'h5A5A);
    chk("led_after_reset", led_out, 8'h00);

    for (int k = 0; k < 600; k++) begin
      sw_in = 8'($urandom);
      d     = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       a = 9'h020;
        1:       a = 9'h021;
        2:       a = 9'h0FF;
        3:       a = LED_A;
        4:       a = SW_A;
        default: a = 9'($urandom_range(0, 511));
      endcase
      sel = $urandom_range(0, 9);
      if (sel < 2)       idle(C_NONE, $urandom_range(1, 2));
      else if (sel == 2) idle(C_RSV, 1);
      else if (sel < 6)  do_cmd(C_RD, a, d);
      else               do_cmd(C_WR, a, d);
      if (k == 300) apply_reset(2);
    end
    idle(C_NONE, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, want finish earlier", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
